// File: rtl/uart_tx_fifo_if.sv
// Write/status bundle between the data-memory I/O decode (master) and the
// buffered UART transmitter (slave).
interface uart_tx_fifo_if #(
  parameter int CNT_W = 5
);
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             full;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;

  modport master (
    output wr_en, wr_data,
    input  full, busy, fifo_count, overflow
  );

  modport slave (
    input  wr_en, wr_data,
    output full, busy, fifo_count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes pushed through the I/O bus are queued in a
// circular FIFO and serialised LSB first onto a registered, idle-high line.
// Frame is 8N1 by default; defining UART_TX_PARITY_EN inserts an even-parity
// bit after the data bits (8E1).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = 5
) (
  input  logic              CLK,
  input  logic              RST,
  uart_tx_fifo_if.slave     bus,
  output logic              UART_RXD_OUT
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  logic [2:0]        state;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
`ifdef UART_TX_PARITY_EN
  logic              parity;
`endif

  logic full, empty, push, pop, baud_done;

  // full is taken from the registered count, so a push in the same cycle as a
  // pop from a full FIFO is still refused
  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign push      = bus.wr_en && !full;
  assign baud_done = (baud == BAUD_LAST);
  // head is consumed either from idle or straight out of a stop bit
  assign pop       = !empty && ((state == S_IDLE) || ((state == S_STOP) && baud_done));

  assign bus.full       = full;
  assign bus.busy       = (state != S_IDLE) || !empty;
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow;

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      if (bus.wr_en && full) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  // Transmit FSM: line value is registered alongside the state change so each
  // bit appears on the edge its state is entered
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      baud         <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      UART_RXD_OUT <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity       <= 1'b0;
`endif
    end else begin
      if (state != S_IDLE) baud <= baud_done ? '0 : baud + BAUD_W'(1);
      case (state)
        S_IDLE: begin
          UART_RXD_OUT <= 1'b1;
          baud         <= '0;
          if (pop) begin
            state        <= S_START;
            shreg        <= mem[rd_ptr];
            UART_RXD_OUT <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity       <= ^mem[rd_ptr];
`endif
          end
        end
        S_START: begin
          if (baud_done) begin
            state        <= S_DATA;
            bit_idx      <= '0;
            UART_RXD_OUT <= shreg[0];
          end
        end
        S_DATA: begin
          if (baud_done) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state        <= S_PARITY;
              UART_RXD_OUT <= parity;
`else
              state        <= S_STOP;
              UART_RXD_OUT <= 1'b1;
`endif
            end else begin
              bit_idx      <= bit_idx + 3'd1;
              UART_RXD_OUT <= shreg[1];
              shreg        <= {1'b0, shreg[7:1]};
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_done) begin
            state        <= S_STOP;
            UART_RXD_OUT <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (baud_done) begin
            if (pop) begin
              // back-to-back frame: no idle gap after the stop bit
              state        <= S_START;
              shreg        <= mem[rd_ptr];
              UART_RXD_OUT <= 1'b0;
`ifdef UART_TX_PARITY_EN
              parity       <= ^mem[rd_ptr];
`endif
            end else begin
              state        <= S_IDLE;
              UART_RXD_OUT <= 1'b1;
            end
          end
        end
        default: begin
          state        <= S_IDLE;
          UART_RXD_OUT <= 1'b1;
        end
      endcase
    end
  end

endmodule
